rx_det_array: RTL and testbench



---
 rtl/rx_det_array.sv | 99 +++++++++
 tb/tb_rx_det_array.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_det_array.sv
// Multi-lane receiver-detect model: per-lane req/ack/vld handshake, per-lane latency skew,
// registered detected-lane count. Optional fault_mask port under `define RX_DET_FAULT_INJ_EN.
module rx_det_array #(
    parameter  int LANES        = 4,
    parameter  int DELAY_CYCLES = 500,
    parameter  int SKEW_CYCLES  = 0,
    localparam int CNT_W        = $clog2(DELAY_CYCLES + (LANES - 1) * SKEW_CYCLES + 1),
    localparam int DC_W         = $clog2(LANES + 1)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef RX_DET_FAULT_INJ_EN
    input  logic [LANES-1:0] fault_mask,
`endif
    input  logic [LANES-1:0] rx_present,
    input  logic [LANES-1:0] rx_det_req,
    output logic [LANES-1:0] rx_det_ack,
    output logic [LANES-1:0] rx_det_vld,
    output logic [DC_W-1:0]  det_count
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, WAIT_LOW} state_e;

    state_e           state_q [LANES];
    state_e           state_d [LANES];
    logic [CNT_W-1:0] cnt_q   [LANES];
    logic [CNT_W-1:0] cnt_d   [LANES];
    logic [LANES-1:0] vld_q, vld_d;
    logic [DC_W-1:0]  det_count_q, det_count_d;
    logic [LANES-1:0] present_eff;

    // Counter value on the last BUSY edge of a lane: lane latency minus one.
    function automatic logic [CNT_W-1:0] last_cnt(input int lane);
        return CNT_W'(DELAY_CYCLES + lane * SKEW_CYCLES - 1);
    endfunction

`ifdef RX_DET_FAULT_INJ_EN
    assign present_eff = rx_present & ~fault_mask;
`else
    assign present_eff = rx_present;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        vld_d       = vld_q;
        rx_det_ack  = '0;
        det_count_d = '0;
        for (int i = 0; i < LANES; i++) begin
            state_d[i]    = state_q[i];
            cnt_d[i]      = cnt_q[i];
            rx_det_ack[i] = (state_q[i] == DONE);
            case (state_q[i])
                IDLE: begin
                    if (rx_det_req[i]) begin
                        state_d[i] = BUSY;
                        cnt_d[i]   = '0;
                    end
                end
                BUSY: begin
                    if (!rx_det_req[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == last_cnt(i)) begin
                        state_d[i] = DONE;
                        cnt_d[i]   = '0;
                        vld_d[i]   = present_eff[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                DONE:     state_d[i] = rx_det_req[i] ? WAIT_LOW : IDLE;
                WAIT_LOW: if (!rx_det_req[i]) state_d[i] = IDLE;
                default:  state_d[i] = IDLE;
            endcase
            det_count_d = det_count_d + DC_W'(vld_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all lanes update from pre-edge values.
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            vld_q       <= '0;
            det_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vld_q       <= vld_d;
            det_count_q <= det_count_d;
        end
    end

    assign rx_det_vld = vld_q;
    assign det_count  = det_count_q;

endmodule

// File: tb/tb_rx_det_array.sv
// Bench for rx_det_array: two instances (D=8/skew=2 and D=1/skew=0) on shared stimulus,
// checked against a timestamp-based lane model plus directed tables and sequences.
module tb_rx_det_array;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] pres = '0;
    logic [3:0] fmask = '0;
    logic [3:0] ack_a, vld_a, ack_b, vld_b;
    logic [2:0] cnt_a, cnt_b;

    always #5 clk = ~clk;

    rx_det_array #(.LANES(4), .DELAY_CYCLES(8), .SKEW_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst),
`ifdef RX_DET_FAULT_INJ_EN
        .fault_mask(fmask),
`endif
        .rx_present(pres), .rx_det_req(req),
        .rx_det_ack(ack_a), .rx_det_vld(vld_a), .det_count(cnt_a)
    );

    rx_det_array #(.LANES(4), .DELAY_CYCLES(1), .SKEW_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst),
`ifdef RX_DET_FAULT_INJ_EN
        .fault_mask(fmask),
`endif
        .rx_present(pres), .rx_det_req(req),
        .rx_det_ack(ack_b), .rx_det_vld(vld_b), .det_count(cnt_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cycle = 0;

    // Reference model: a lane remembers when its request started and completes once
    // exactly D_i edges have passed with the request still high.
    bit m_pend [2][4];
    int m_start[2][4];
    bit m_blk  [2][4];
    bit m_ack  [2][4];
    bit m_vld  [2][4];
    int cnt_exp[2];

    function automatic int lat(input int k, input int i);
        return (k == 0) ? 8 + 2 * i : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int pc;
            pc = 0;
            for (int i = 0; i < 4; i++) pc += int'(m_vld[k][i]);
            cnt_exp[k] = rst ? 0 : pc;
            for (int i = 0; i < 4; i++) begin
                bit r, p;
                r = req[i];
                p = pres[i];
`ifdef RX_DET_FAULT_INJ_EN
                p = p & ~fmask[i];
`endif
                if (rst) begin
                    m_pend[k][i] = 0; m_blk[k][i] = 0; m_ack[k][i] = 0; m_vld[k][i] = 0;
                end else if (m_ack[k][i]) begin
                    m_ack[k][i] = 0;
                    m_blk[k][i] = r;
                end else if (m_pend[k][i]) begin
                    if (!r) m_pend[k][i] = 0;
                    else if (cycle - m_start[k][i] == lat(k, i)) begin
                        m_pend[k][i] = 0;
                        m_ack[k][i]  = 1;
                        m_vld[k][i]  = p;
                    end
                end else if (m_blk[k][i]) begin
                    if (!r) m_blk[k][i] = 0;
                end else if (r) begin
                    m_pend[k][i]  = 1;
                    m_start[k][i] = cycle;
                end
            end
        end
    endtask

    function automatic logic [3:0] exp_ack(input int k);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_ack[k][i];
        return v;
    endfunction

    function automatic logic [3:0] exp_vld(input int k);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_vld[k][i];
        return v;
    endfunction

    // One clock edge: advance the model with the sampled inputs, then compare 1 ns later.
    task automatic tick();
        @(posedge clk);
        cycle++;
        model_step();
        #1;
        check("model_ack_a", 32'(ack_a), 32'(exp_ack(0)));
        check("model_vld_a", 32'(vld_a), 32'(exp_vld(0)));
        check("model_cnt_a", 32'(cnt_a), 32'(cnt_exp[0]));
        check("model_ack_b", 32'(ack_b), 32'(exp_ack(1)));
        check("model_vld_b", 32'(vld_b), 32'(exp_vld(1)));
        check("model_cnt_b", 32'(cnt_b), 32'(cnt_exp[1]));
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] pres;
        logic [3:0] exp_vld;
        int         exp_cnt;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int   first_a[4];
        int   first_b[4];
        int   e0, acks;
        logic prior;

        tbl[0] = '{4'b1111, 4'b1111, 4'b1111, 4};
        tbl[1] = '{4'b1111, 4'b0101, 4'b0101, 2};
        tbl[2] = '{4'b1111, 4'b0000, 4'b0000, 0};
        tbl[3] = '{4'b1111, 4'b1010, 4'b1010, 2};
        tbl[4] = '{4'b0011, 4'b0011, 4'b1011, 3};
        tbl[5] = '{4'b1100, 4'b0100, 4'b0111, 3};

        // Reset state
        tick(); tick();
        check("rst_ack_a", 32'(ack_a), 0);
        check("rst_vld_a", 32'(vld_a), 0);
        check("rst_cnt_a", 32'(cnt_a), 0);
        rst = 1'b0;
        tick();

        // All lanes requested: acks at E0+8/10/12/14 (dut_a) and E0+1 (dut_b)
        req  = 4'b1111;
        pres = 4'b1111;
        e0   = cycle + 1;
        for (int i = 0; i < 4; i++) begin first_a[i] = -1; first_b[i] = -1; end
        repeat (20) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (ack_a[i] && first_a[i] < 0) first_a[i] = cycle - e0;
                if (ack_b[i] && first_b[i] < 0) first_b[i] = cycle - e0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ack_lat_a%0d", i), 32'(first_a[i]), 32'(8 + 2 * i));
            check($sformatf("ack_lat_b%0d", i), 32'(first_b[i]), 1);
        end
        check("t1_cnt_a", 32'(cnt_a), 4);

        // Table of detect rounds, each followed by a long hold with no further ack
        for (int t = 0; t < 6; t++) begin
            req = '0;
            tick(); tick();
            req  = tbl[t].req;
            pres = tbl[t].pres;
            repeat (20) tick();
            check($sformatf("tbl%0d_vld_a", t), 32'(vld_a), 32'(tbl[t].exp_vld));
            check($sformatf("tbl%0d_cnt_a", t), 32'(cnt_a), 32'(tbl[t].exp_cnt));
            check($sformatf("tbl%0d_vld_b", t), 32'(vld_b), 32'(tbl[t].exp_vld));
            check($sformatf("tbl%0d_cnt_b", t), 32'(cnt_b), 32'(tbl[t].exp_cnt));
            acks = 0;
            repeat (100) begin
                tick();
                acks += int'(|ack_a) + int'(|ack_b);
            end
            check($sformatf("tbl%0d_no_retrigger", t), 32'(acks), 0);
        end

        // Lane 1 abort at E0+5, then re-request
        req = '0;
        tick(); tick();
        prior   = vld_a[1];
        pres    = 4'b1111;
        pres[1] = ~prior;
        req     = 4'b1111;
        acks    = 0;
        repeat (5) begin tick(); acks += int'(ack_a[1]); end
        req[1] = 1'b0;
        repeat (21) begin tick(); acks += int'(ack_a[1]); end
        check("abort_no_ack", 32'(acks), 0);
        check("abort_vld_kept", 32'(vld_a[1]), 32'(prior));
        req[1] = 1'b1;
        e0 = cycle + 1;
        first_a[1] = -1;
        repeat (20) begin
            tick();
            if (ack_a[1] && first_a[1] < 0) first_a[1] = cycle - e0;
        end
        check("rereq_lat", 32'(first_a[1]), 10);

        // Reset at E0+6 with all lanes busy
        req = '0;
        tick(); tick();
        req = 4'b1111;
        repeat (6) tick();
        rst = 1'b1;
        req = '0;
        tick();
        check("midrst_ack_a", 32'(ack_a), 0);
        check("midrst_vld_a", 32'(vld_a), 0);
        check("midrst_cnt_a", 32'(cnt_a), 0);
        check("midrst_vld_b", 32'(vld_b), 0);
        rst  = 1'b0;
        acks = 0;
        repeat (30) begin tick(); acks += int'(|ack_a) + int'(|ack_b); end
        check("postrst_no_ack", 32'(acks), 0);

`ifdef RX_DET_FAULT_INJ_EN
        // Faulted lane 3: normal ack, result forced to not-detected
        fmask = 4'b1000;
        pres  = 4'b1111;
        req   = 4'b1111;
        acks  = 0;
        repeat (20) begin
            tick();
            for (int i = 0; i < 4; i++) acks += int'(ack_a[i]);
        end
        check("fault_acks", 32'(acks), 4);
        check("fault_vld_a", 32'(vld_a), 32'(4'b0111));
        tick();
        check("fault_cnt_a", 32'(cnt_a), 3);
        req = '0;
        fmask = '0;
        tick(); tick();
`endif

        // Random traffic against the model
        repeat (3000) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(15) == 0) req[i] = ~req[i];
            pres = 4'($urandom);
            rst  = ($urandom_range(299) == 0);
`ifdef RX_DET_FAULT_INJ_EN
            fmask = 4'($urandom);
`endif
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
